imm_extend_unit: RTL
====================

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 The block SHALL have parameter IN_W, default 16: immediate input width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 32: extended output width in bits; legal only if OUT_W >= IN_W+2.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1: synchronous discard of all buffered entries (pipeline squash).
REQ-006 The block SHALL have port in_valid, input, 1: in_imm and in_mode are valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1: the block can accept an entry this cycle.
REQ-008 The block SHALL have port in_imm, input, IN_W: raw immediate field.
REQ-009 The block SHALL have port in_mode, input, 2: extension mode (encoding in REQ-013).
REQ-010 The block SHALL have port out_valid, output, 1: out_data holds a result.
REQ-011 The block SHALL have port out_ready, input, 1: the consumer accepts out_data this cycle.
REQ-012 The block SHALL have port out_data, output, OUT_W: extended result.

Function
REQ-013 Mode encoding SHALL be: 00 SEXT = {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}; 01 ZEXT = {zeros, in_imm}; 10 UPPER = in_imm placed at bits [OUT_W-1:OUT_W-IN_W], lower bits zero; 11 BRANCH = SEXT result shifted left 2, top 2 bits discarded.
REQ-014 The result SHALL be computed at acceptance (in_valid && in_ready) and stored; no arithmetic SHALL occur on the output side.
REQ-015 Storage SHALL be a 2-entry FIFO (skid buffer) with count 0..2; in_ready SHALL equal (count < 2) and be driven only from registers.
REQ-016 Latency SHALL be 1 cycle: an entry accepted in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1 when the buffer was empty.
REQ-017 out_valid SHALL equal (count != 0); out_data SHALL be the oldest entry; a pop occurs when out_valid && out_ready.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged and preserve order; this SHALL be legal at count 1 and count 2 (count 2 accepts nothing because in_ready=0).
REQ-019 Results SHALL be delivered strictly in acceptance order; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-020 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 flush=1 SHALL set count to 0 next cycle and ignore any simultaneous push or pop; in_ready SHALL be 1 the cycle after flush.
REQ-022 Read/write pointers SHALL be 1 bit each and wrap 1->0.

Reset
REQ-023 reset=1 at a clock edge SHALL set count, both pointers, and out_valid to 0 and in_ready to 1; reset SHALL override flush and any handshake in that cycle.
REQ-024 out_data SHALL read 0 after reset until the first accepted entry; storage contents need not be cleared otherwise.
REQ-025 Reset asserted mid-stream SHALL discard all buffered entries; no result from before reset SHALL appear afterwards.

Structure
REQ-026 Mode encodings (SEXT, ZEXT, UPPER, BRANCH) and the default widths SHALL live in the shared processor constants package used by the decode stage.
REQ-027 The pure extension logic SHALL be a combinational sub-module, imm_extend_core (parameters IN_W, OUT_W; inputs imm and mode; output ext); the buffer/handshake logic SHALL stay in imm_extend_unit.

Verification
REQ-028 Mode sweep, out_ready=1: 0x8004 SEXT -> 0xFFFF8004; ZEXT -> 0x00008004; UPPER -> 0x80040000; BRANCH -> 0xFFFE0010; each one cycle after acceptance.
REQ-029 Backpressure: out_ready=0, push 0x0001, 0x0002, 0x0003 (SEXT) back to back -> first two accepted, in_ready=0 from the third cycle, out_data held at 0x00000001; then out_ready=1 -> 0x1, 0x2 in order, then 0x3 accepted.
REQ-030 Simultaneous push/pop at count 1 for 10 cycles -> count stays 1, output sequence equals input sequence delayed one cycle.
REQ-031 Flush at count 2 with a concurrent pop attempt -> out_valid=0 and in_ready=1 next cycle; neither flushed entry ever appears.
REQ-032 Reset mid-stream at count 2 -> out_valid=0, in_ready=1, out_data=0 next cycle; a following push of 0x7FFF (SEXT) yields 0x00007FFF.
REQ-033 Parameter instance IN_W=12, OUT_W=32: 0x800 SEXT -> 0xFFFFF800; UPPER -> 0x80000000; BRANCH -> 0xFFFFE000.

Source files
------------

// File: rtl/imm_extend_pkg.sv
// Shared decode-stage constants: immediate extension modes and default widths.
package imm_extend_pkg;

  localparam int DEFAULT_IN_W  = 16;
  localparam int DEFAULT_OUT_W = 32;

  typedef enum logic [1:0] {
    IMM_SEXT   = 2'b00,
    IMM_ZEXT   = 2'b01,
    IMM_UPPER  = 2'b10,
    IMM_BRANCH = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/imm_extend_core.sv
// Pure combinational immediate extension: sign/zero extend, upper placement, branch offset.
module imm_extend_core
  import imm_extend_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int OUT_W = DEFAULT_OUT_W
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] branch;

  assign sext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zext   = {{(OUT_W-IN_W){1'b0}}, imm};
  assign upper  = {imm, {(OUT_W-IN_W){1'b0}}};
  // Word-aligned branch offset: the two MSBs of the sign extension fall off.
  assign branch = {sext[OUT_W-3:0], 2'b00};

  always_comb begin
    ext = sext;
    case (imm_mode_e'(mode))
      IMM_SEXT:   ext = sext;
      IMM_ZEXT:   ext = zext;
      IMM_UPPER:  ext = upper;
      IMM_BRANCH: ext = branch;
      default:    ext = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate extender with a 2-entry skid buffer; the result is computed at acceptance.
module imm_extend_unit
  import imm_extend_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int OUT_W = DEFAULT_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid/data never wait on ready, and ready/valid here come straight from flops.

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] mem_q [2];
  logic [OUT_W-1:0] mem_d [2];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop;

  imm_extend_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .imm (in_imm),
    .mode(in_mode),
    .ext (ext)
  );

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_comb begin
    mem_d[0]    = mem_q[0];
    mem_d[1]    = mem_q[1];
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = ext;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
    // Flags are registered from the next count so the ports are pure flop outputs.
    in_ready_d  = (count_d != 2'd2);
    out_valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem_q[rd_ptr_q];

endmodule
